// File: rtl/req_arbiter_pkg.sv
// Shared types and default sizing for the request arbiter (package arb_pkg).
package arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int ARB_N_DEFAULT        = 4;
  localparam int ARB_MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/req_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface req_arbiter_if #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
);
  // req is a level held high while the resource is wanted; gnt is a registered
  // one-hot that stays high until req[owner] falls or the hold limit is hit.
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_valid;
  logic            timeout;

  modport master (output req, input gnt, gnt_id, gnt_valid, timeout);
  modport slave  (input req, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/req_arbiter_prio_pick.sv
// Combinational priority search: rotate req so start is the top slot, pick the
// highest set bit, then map the winner back to its original index.
module prio_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] start,
  output logic [ID_W-1:0] win_id,
  output logic            any_valid
);

  logic [N-1:0] rot;
  int           hi;

  always_comb begin
    rot       = '0;
    hi        = 0;
    any_valid = 1'b0;
    // rot[N-1] holds req[start], rot[N-2] holds req[start-1], and so on.
    for (int j = 0; j < N; j++) begin
      rot[j] = req[(j + int'(start) + 1) % N];
    end
    for (int j = 0; j < N; j++) begin
      if (rot[j]) begin
        hi        = j;
        any_valid = 1'b1;
      end
    end
    win_id = ID_W'((hi + int'(start) + 1) % N);
  end

endmodule

// File: rtl/req_arbiter.sv
// N-way request arbiter with a hold limit; define ARB_ROUND_ROBIN_EN for
// rotating priority, otherwise the highest requesting index always wins.
module req_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N_DEFAULT,
  parameter int ID_W     = $clog2(N),
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  req_arbiter_if.slave bus,
  output arb_state_t   dbg_state
);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic            timeout_q, timeout_d;

  logic [ID_W-1:0] pick_start;
  logic [ID_W-1:0] pick_id;
  logic            pick_any;

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_id_q, last_id_d;
  // Search begins just below the previous winner, so it is considered last.
  assign pick_start = (last_id_q == '0) ? ID_W'(N - 1) : last_id_q - ID_W'(1);
`else
  assign pick_start = ID_W'(N - 1);
`endif

  prio_pick #(.N(N), .ID_W(ID_W)) u_pick (
    .req       (bus.req),
    .start     (pick_start),
    .win_id    (pick_id),
    .any_valid (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_id_d   = last_id_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
        if (pick_any) begin
          state_d     = BUSY;
          owner_d     = pick_id;
          gnt_d       = N'(1) << pick_id;
          gnt_id_d    = pick_id;
          gnt_valid_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          last_id_d   = pick_id;
`endif
        end
      end
      BUSY: begin
        // A normal release takes precedence over hitting the limit.
        if (!bus.req[owner_q] || (hold_cnt_q == CNT_W'(MAX_HOLD - 1))) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_id_d    = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          timeout_d   = bus.req[owner_q];
        end else begin
          hold_cnt_d  = hold_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_id_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_id_q   <= last_id_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Directed bench for req_arbiter: reset, fixed priority, non-preemption,
// hold-limit timeout, same-cycle release, rotation order and mid-grant reset.
module tb_req_arbiter;
  import arb_pkg::*;

  localparam int N        = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 16;

  logic clk = 1'b0;
  logic rst_n;
  arb_state_t dbg_state;
  int checks = 0;
  int errors = 0;
  logic [ID_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  req_arbiter_if #(.N(N), .ID_W(ID_W)) bus ();

  req_arbiter #(.N(N), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ID_W-1:0] enc(input logic [N-1:0] g);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = ID_W'(i);
    return r;
  endfunction

  task automatic check_out(input string tag, input logic [N-1:0] eg, input logic et);
    check({tag, ".gnt"},       32'(bus.gnt),       32'(eg));
    check({tag, ".gnt_id"},    32'(bus.gnt_id),    32'(enc(eg)));
    check({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(|eg));
    check({tag, ".timeout"},   32'(bus.timeout),   32'(et));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [ID_W-1:0] e;
    logic [N-1:0]    oh;

    rst_n   = 1'b0;
    bus.req = '0;
    step();
    step();
    rst_n = 1'b1;
    check_out("reset", 4'b0000, 1'b0);
    check("reset.state", 32'(dbg_state), 32'(IDLE));
    for (int i = 0; i < 5; i++) begin
      step();
      check_out("idle", 4'b0000, 1'b0);
    end

    // Fixed priority: 0110 grants 2, then 1 after 2 releases.
    bus.req = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("p0110", 4'b0100, 1'b0);
    end
    bus.req = 4'b0010;
    step();
    check_out("rel2", 4'b0000, 1'b0);
    step();
    check_out("g1", 4'b0010, 1'b0);

    // Higher request during BUSY must not preempt.
    bus.req = 4'b1010;
    step();
    check_out("nopre", 4'b0010, 1'b0);
    bus.req = 4'b1000;
    step();
    check_out("rel1", 4'b0000, 1'b0);
    step();
    check_out("g3", 4'b1000, 1'b0);
    bus.req = 4'b0000;
    step();
    check_out("rel3", 4'b0000, 1'b0);
    step();
    check_out("idle2", 4'b0000, 1'b0);

    // Hold limit: 16 grant cycles, timeout pulse, then regrant.
    bus.req = 4'b0001;
    for (int i = 0; i < MAX_HOLD; i++) begin
      step();
      check_out("hold", 4'b0001, 1'b0);
    end
    step();
    check_out("tout", 4'b0000, 1'b1);
    check("tout.state", 32'(dbg_state), 32'(IDLE));
    step();
    check_out("regrant", 4'b0001, 1'b0);

    // Release on the very cycle the limit is reached: no timeout.
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      step();
      check_out("hold2", 4'b0001, 1'b0);
    end
    bus.req = 4'b0000;
    step();
    check_out("limrel", 4'b0000, 1'b0);
    step();
    check_out("limrel_idle", 4'b0000, 1'b0);

    // Each owner releases after one cycle while the others keep requesting.
`ifdef ARB_ROUND_ROBIN_EN
    exp_q = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
    exp_q = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
    bus.req = 4'b1111;
    step();
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      oh = N'(1) << e;
      check_out("rot", oh, 1'b0);
      bus.req = 4'b1111 & ~oh;
      step();
      check_out("rot_idle", 4'b0000, 1'b0);
      bus.req = 4'b1111;
      step();
    end
`ifdef ARB_ROUND_ROBIN_EN
    check_out("rot_next", 4'b0100, 1'b0);
`else
    check_out("rot_next", 4'b1000, 1'b0);
`endif

    // Reset at the limit cycle: grant drops with no timeout pulse.
    for (int i = 0; i < MAX_HOLD - 1; i++) step();
    rst_n = 1'b0;
    step();
    check_out("rstmid", 4'b0000, 1'b0);
    check("rstmid.state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    step();
    check_out("postrst", 4'b1000, 1'b0);
    bus.req = 4'b0111;
    step();
    check_out("postrst_rel", 4'b0000, 1'b0);
    bus.req = 4'b1111;
    step();
`ifdef ARB_ROUND_ROBIN_EN
    check_out("postrst_next", 4'b0100, 1'b0);
`else
    check_out("postrst_next", 4'b1000, 1'b0);
`endif
    bus.req = 4'b0000;
    step();
    check_out("final_rel", 4'b0000, 1'b0);
    step();
    check_out("final_idle", 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_arbiter.md
# req_arbiter

Shares one resource among N requesters using a registered request/grant handshake. Arbitration uses a priority search: fixed priority with the highest index winning, or rotating priority when compiled in. A hold counter bounds how long any owner keeps the grant. The block sits in front of the shared datapath, and its encoded grant ID drives the datapath's select lines.

## Interface
- N, default 4: number of requesters, 2..16.
- ID_W, default $clog2(N): width of the encoded grant ID.
- MAX_HOLD, default 16: maximum number of consecutive cycles one grant may stay high, ≥2.
- CNT_W, default $clog2(MAX_HOLD+1): width of the hold counter.
- clk, input, 1: single clock; all logic is on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- req, input, N: per-requester request level; held high while the resource is wanted.
- gnt, output, N: one-hot grant, registered.
- gnt_id, output, ID_W: encoded index of the current owner; 0 when gnt_valid is 0.
- gnt_valid, output, 1: high while any grant is asserted (equals |gnt).
- timeout, output, 1: one-cycle pulse on the cycle the grant is forcibly removed.

## Operation
- FSM has two states: IDLE and BUSY.
- IDLE:
  - If req is nonzero, the winner is chosen by the priority search and latched into owner.
  - Next state is BUSY, the hold counter is cleared, and gnt/gnt_id/gnt_valid become registered outputs for that owner.
  - If req is zero, stay in IDLE.
- BUSY:
  - The hold counter increments every cycle gnt is high.
  - Exit to IDLE when req[owner] is sampled low (normal release), or when hold_cnt == MAX_HOLD-1 (forced release).
  - On forced release while req[owner] is still high, timeout pulses with the grant drop.
  - If release and the limit occur on the same cycle, the release is normal and timeout stays low.
- Priority search, fixed mode: highest set index of req wins.
- Only req bits are considered. Requests from other inputs during BUSY are ignored and do not preempt the owner.
- A forcibly released requester that keeps req high is eligible again at the next arbitration.
- On a grant, last_id is loaded with the winner. It is used only in rotating mode.
- On reset:
  - State returns to IDLE.
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold_cnt=0, last_id=0.
  - Reset during BUSY drops the grant on the next cycle with no timeout pulse.

## Timing
- Grant latency: req sampled high at edge t in IDLE, gnt high during cycle t+1.
- Release latency: req[owner] sampled low at edge t, gnt low during cycle t+1.
- Forced release: a grant lasts at most MAX_HOLD cycles.
- There is at least one IDLE cycle between consecutive grants, so handover is never back-to-back. The minimum grant period for a continuously requesting pair is 1 grant cycle + 1 idle cycle.
- timeout is high for exactly one cycle, coincident with the first cycle gnt is low.
- All outputs are registered and there are no combinational paths from req to outputs.

## Configuration
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - Search order starts at last_id-1 and descends, wrapping modulo N; last_id is searched last.
  - After reset (last_id=0) the order is N-1…0, identical to fixed mode.
- Undefined: fixed priority, highest index wins, and the last_id register is not instantiated.
- Ports and timing are identical in both builds.

## Structure
- Package arb_pkg holds:
  - typedef enum logic {IDLE, BUSY} arb_state_t;
  - default constants for N and MAX_HOLD.
- Sub-module prio_pick is combinational and takes req and start index. It rotates, finds the highest set bit, and un-rotates. Outputs are winner ID and any-valid.
- In fixed mode prio_pick is instantiated with start = N-1.
- req_arbiter holds the FSM, owner/last_id registers, the hold counter and the output registers.

## Test plan
- Reset, then req=4'b0000 for 5 cycles: gnt=0, gnt_valid=0, gnt_id=0, timeout=0 throughout.
- Fixed priority, req=4'b0110 held for 3 cycles then dropped:
  - gnt=4'b0100 and gnt_id=2 one cycle after sampling.
  - gnt=0 one cycle after bit 2 falls.
  - The following arbitration grants requester 1.
- Rotating mode (ARB_ROUND_ROBIN_EN), req=4'b1111 with each owner releasing after 1 cycle: grant order is 3, 2, 1, 0, 3 with one idle cycle between grants.
- Timeout with MAX_HOLD=16, req=4'b0001 held continuously:
  - gnt high for exactly 16 cycles.
  - timeout=1 on the 17th cycle with gnt=0.
  - Re-granted on the following cycle.
- Same-cycle release at the limit: req[owner] falls on the cycle hold_cnt==15, so the grant drops and timeout stays 0.
- Reset mid-grant: rst_n low for one edge during BUSY, so gnt=0, timeout=0 and state is IDLE the next cycle. In rotating mode last_id=0 and arbitration order is restored to 3…0.
